// File: rtl/rv_width_upsizer.sv
// rv_width_upsizer: packs RATIO narrow ready/valid beats into one wide word.
// Lane 0 holds the first accepted beat (little-endian packing).
// Optional packet flush on last_in is enabled by defining RV_UPSIZER_LAST_EN.
module rv_width_upsizer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          last_in,
  output logic                          ready_out,
  output logic                          valid_out,
  output logic [RATIO*DATA_WIDTH-1:0]   data_out,
  output logic [RATIO-1:0]              keep_out,
  output logic                          last_out,
  input  logic                          ready_in
);

  localparam int unsigned   CW      = $clog2(RATIO);
  localparam int unsigned   PW      = (RATIO-1)*DATA_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO-1);

  logic [CW-1:0]               cnt;
  logic [PW-1:0]               pack_q;
  logic [RATIO*DATA_WIDTH-1:0] pack_ext;
  logic [RATIO*DATA_WIDTH-1:0] word_d;
  logic [RATIO-1:0]            keep_d;
  logic                        flush;
  logic                        complete;
  logic                        out_block;
  logic                        accept;

`ifdef RV_UPSIZER_LAST_EN
  assign flush = last_in;
`else
  logic unused_last;
  assign unused_last = last_in;
  assign flush       = 1'b0;
`endif

  // A beat completes a word either at the last lane or when it flushes a packet.
  assign complete  = (cnt == CNT_MAX) | flush;
  assign out_block = valid_out & ~ready_in;
  // Only a completing beat needs the output register free (it may drain this edge).
  assign ready_out = ~reset & (~out_block | ~complete);
  assign accept    = valid_in & ready_out;

  // Top lane padded with zeros so every lane index below RATIO is addressable.
  assign pack_ext = {{DATA_WIDTH{1'b0}}, pack_q};

  // Assemble the outgoing word: stored lanes below cnt, the incoming beat at cnt,
  // zeros above (only reachable on a flush).
  always_comb begin
    word_d = '0;
    keep_d = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) < cnt) begin
        word_d[i*DATA_WIDTH +: DATA_WIDTH] = pack_ext[i*DATA_WIDTH +: DATA_WIDTH];
        keep_d[i] = 1'b1;
      end else if (CW'(i) == cnt) begin
        word_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
        keep_d[i] = 1'b1;
      end
    end
  end

  // Pack register, lane counter and output register with its valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      pack_q    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (valid_out & ready_in) begin
        valid_out <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          data_out  <= word_d;
          keep_out  <= keep_d;
          last_out  <= flush;
          valid_out <= 1'b1;
          cnt       <= '0;
        end else begin
          for (int unsigned i = 0; i < RATIO-1; i++) begin
            if (CW'(i) == cnt) begin
              pack_q[i*DATA_WIDTH +: DATA_WIDTH] <= data_in;
            end
          end
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_width_upsizer.sv
// Testbench for rv_width_upsizer: directed scenarios plus randomized traffic
// against a queue-based packing model.
`timescale 1ns/1ps
module tb_rv_width_upsizer;

  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;
`ifdef RV_UPSIZER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          last_in;
  logic          ready_out;
  logic          valid_out;
  logic [R*DW-1:0] data_out;
  logic [R-1:0]  keep_out;
  logic          last_out;
  logic          ready_in;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [R*DW-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] part_q[$];

  always #5 clk = ~clk;

  rv_width_upsizer #(
    .DATA_WIDTH (DW),
    .RATIO      (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_in  (ready_in)
  );

  // Reference: collect beats, emit a word when RATIO beats gathered or a flush is seen.
  task automatic model_beat(input logic [DW-1:0] d, input logic l);
    word_t w;
    part_q.push_back(d);
    if (part_q.size() == R || (LAST_EN && l)) begin
      w.data = '0;
      w.keep = '0;
      w.last = LAST_EN && l;
      foreach (part_q[i]) begin
        w.data[i*DW +: DW] = part_q[i];
        w.keep[i] = 1'b1;
      end
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  // One cycle: drive at the falling edge, sample handshake, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                      output logic rdy, output logic acc);
    valid_in = v;
    data_in  = d;
    last_in  = l;
    ready_in = r;
    #1;
    rdy = ready_out;
    acc = v & ready_out;
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (acc) model_beat(d, l);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    reset    = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    last_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    part_q.delete();
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    last_in  = 1'b0;
    ready_in = 1'b0;
    #1;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", ready_out); end
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    part_q.delete();
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
    total++; if (keep_out !== '0) begin bad++; $display("FAIL reset_keep: got %h want 0", keep_out); end
    total++; if (last_out !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", last_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", ready_out); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic rdy, acc;
    logic [DW-1:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, beats[k], 1'b0, 1'b1, rdy, acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL basic_accept%0d: got %b want 1", k, acc); end
      if (k == 2) begin
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", valid_out); end
      end
    end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", valid_out); end
    total++; if (data_out !== 32'h44332211) begin bad++; $display("FAIL basic_data: got %h want 44332211", data_out); end
    total++; if (keep_out !== 4'hF) begin bad++; $display("FAIL basic_keep: got %h want f", keep_out); end
    total++; if (last_out !== 1'b0) begin bad++; $display("FAIL basic_last: got %b want 0", last_out); end
    step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", valid_out); end
  endtask

  task automatic test_back_to_back;
    logic rdy, acc;
    int pulses;
    logic [R*DW-1:0] words [3];
    words  = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, DW'(17*(k+1)), 1'b0, 1'b1, rdy, acc);
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", k, rdy); end
      if (valid_out === 1'b1) begin
        if (pulses < 3) begin
          total++; if (data_out !== words[pulses]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", pulses, data_out, words[pulses]); end
        end
        pulses++;
      end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
  endtask

  task automatic test_backpressure;
    logic rdy, acc;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, DW'(17*(k+1)), 1'b0, 1'b0, rdy, acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept%0d: got %b want 1", k, acc); end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h88, 1'b0, 1'b0, rdy, acc);
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL bp_blocked%0d: got %b want 0", k, rdy); end
      total++; if (valid_out !== 1'b1 || data_out !== 32'h44332211) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 44332211", k, valid_out, data_out);
      end
    end
    step(1'b1, 8'h88, 1'b0, 1'b1, rdy, acc);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", rdy); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_release_valid: got %b want 1", valid_out); end
    total++; if (data_out !== 32'h88776655) begin bad++; $display("FAIL bp_release_data: got %h want 88776655", data_out); end
    step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", valid_out); end
  endtask

  task automatic test_reset_mid;
    logic rdy, acc;
    step(1'b1, 8'hEE, 1'b0, 1'b1, rdy, acc);
    step(1'b1, 8'hFF, 1'b0, 1'b1, rdy, acc);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, DW'(8'hA1 + k), 1'b0, 1'b1, rdy, acc);
    end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rmid_valid: got %b want 1", valid_out); end
    total++; if (data_out !== 32'hA4A3A2A1) begin bad++; $display("FAIL rmid_data: got %h want a4a3a2a1", data_out); end
    total++; if (keep_out !== 4'hF) begin bad++; $display("FAIL rmid_keep: got %h want f", keep_out); end
    step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
  endtask

`ifdef RV_UPSIZER_LAST_EN
  task automatic test_last;
    logic rdy, acc;
    step(1'b1, 8'h01, 1'b0, 1'b1, rdy, acc);
    step(1'b1, 8'h02, 1'b1, 1'b1, rdy, acc);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL last_valid: got %b want 1", valid_out); end
    total++; if (data_out !== 32'h00000201) begin bad++; $display("FAIL last_data: got %h want 00000201", data_out); end
    total++; if (keep_out !== 4'h3) begin bad++; $display("FAIL last_keep: got %h want 3", keep_out); end
    total++; if (last_out !== 1'b1) begin bad++; $display("FAIL last_flag: got %b want 1", last_out); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, DW'(16*(k+1)), 1'b0, 1'b1, rdy, acc);
    end
    total++; if (data_out !== 32'h40302010) begin bad++; $display("FAIL last_next_data: got %h want 40302010", data_out); end
    total++; if (keep_out !== 4'hF || last_out !== 1'b0) begin
      bad++; $display("FAIL last_next_keep: got %h/%b want f/0", keep_out, last_out);
    end
    step(1'b1, 8'h55, 1'b1, 1'b1, rdy, acc);
    total++; if (data_out !== 32'h00000055 || keep_out !== 4'h1 || last_out !== 1'b1) begin
      bad++; $display("FAIL last_single: got %h/%h/%b want 00000055/1/1", data_out, keep_out, last_out);
    end
    step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
  endtask
`else
  task automatic test_last_ignored;
    logic rdy, acc;
    step(1'b1, 8'h01, 1'b0, 1'b1, rdy, acc);
    step(1'b1, 8'h02, 1'b1, 1'b1, rdy, acc);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL noflush_valid: got %b want 0", valid_out); end
    step(1'b1, 8'h03, 1'b0, 1'b1, rdy, acc);
    step(1'b1, 8'h04, 1'b1, 1'b1, rdy, acc);
    total++; if (data_out !== 32'h04030201) begin bad++; $display("FAIL noflush_data: got %h want 04030201", data_out); end
    total++; if (keep_out !== 4'hF || last_out !== 1'b0) begin
      bad++; $display("FAIL noflush_keep: got %h/%b want f/0", keep_out, last_out);
    end
    step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
  endtask
`endif

  task automatic test_random;
    logic rdy, acc, v, r, l, exp_rdy;
    logic [DW-1:0] d;
    int accepted, cycles;
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 60000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      d = DW'($urandom);
      total++; if (valid_out !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cycles, valid_out, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        total++; if (data_out !== exp_q[0].data || keep_out !== exp_q[0].keep || last_out !== exp_q[0].last) begin
          bad++; $display("FAIL rnd_word@%0d: got %h/%h/%b want %h/%h/%b", cycles, data_out, keep_out, last_out,
                          exp_q[0].data, exp_q[0].keep, exp_q[0].last);
        end
      end
      exp_rdy = !(exp_q.size() != 0 && !r) || (part_q.size() != R-1 && !(LAST_EN && l));
      step(v, d, l, r, rdy, acc);
      total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cycles, rdy, exp_rdy); end
      if (acc) accepted++;
      cycles++;
    end
    total++; if (accepted < 10000) begin bad++; $display("FAIL rnd_budget: got %0d beats want 10000", accepted); end
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      total++; if (data_out !== exp_q[0].data) begin
        bad++; $display("FAIL rnd_tail: got %h want %h", data_out, exp_q[0].data);
      end
      step(1'b0, '0, 1'b0, 1'b1, rdy, acc);
    end
    total++; if (valid_out !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_drain: got v=%b q=%0d want v=0 q=0", valid_out, exp_q.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    last_in  = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef RV_UPSIZER_LAST_EN
    test_last();
`else
    test_last_ignored();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rv_width_upsizer.md
Name: rv_width_upsizer

Overview:
- Ready/valid width converter. Packs RATIO consecutive narrow beats of DATA_WIDTH bits into one wide output word of RATIO*DATA_WIDTH bits.
- Sits directly downstream of the skid/full register slice and consumes its valid/data stream.
- Wide words feed wide consumers such as bus-width adapters and memory write ports.
- Fully handshaked on both sides, so back-pressure propagates without loss.

Parameters:
- DATA_WIDTH, 8, width of one input beat.
- RATIO, 4, input beats per output word; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  upstream beat valid
- data_in  input  DATA_WIDTH  upstream beat
- last_in  input  1  final beat of packet (used only with feature)
- ready_out  output  1  block can accept a beat this cycle
- valid_out  output  1  packed word valid
- data_out  output  RATIO*DATA_WIDTH  packed word
- keep_out  output  RATIO  per-lane valid mask
- last_out  output  1  word ends a packet (feature only)
- ready_in  input  1  downstream accepts word

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset values:
  - valid_out=0, data_out=0, keep_out=0, last_out=0.
  - Lane counter cnt=0; pack register cleared.
  - ready_out=0 while reset is high and 1 in the first cycle after.
- Storage:
  - Pack register of RATIO-1 lanes plus counter cnt (0..RATIO-1).
  - Output register (data_out, keep_out, last_out) with its valid flag.
- Input handshake: a beat is accepted when valid_in & ready_out at a rising edge.
- ready_out = (cnt != RATIO-1) | ~valid_out | ready_in.
  - This is a combinational ready_in -> ready_out path and is permitted.
  - No combinational valid_in -> valid_out path.
- Lane order: little-endian. Beat k of a word lands in data_out[k*DATA_WIDTH +: DATA_WIDTH]; the first-accepted beat is lane 0.
- Accepted beat with cnt < RATIO-1 (and not a flush): beat is stored in lane cnt, cnt increments.
- Accepted beat with cnt == RATIO-1 (completion):
  - Pack lanes plus data_in load the output register.
  - keep_out = all ones; valid_out=1 next cycle; cnt -> 0.
  - Latency: final beat accepted at edge N, word visible at valid_out after edge N.
- Output handshake: word consumed when valid_out & ready_in. valid_out then clears unless a completion occurs in the same edge.
- Simultaneous drain and completion: new word loads, valid_out stays 1, giving full throughput of one input beat per cycle.
- Completion while output is full and ready_in=0: blocked, because ready_out=0. The pack register holds; no data loss or overwrite.
- Partial lanes never appear on data_out without the feature.
- data_out and keep_out hold stable while valid_out & ~ready_in.
- Reset mid-operation: partial pack contents and any pending output word are discarded; the counter returns to 0.

Optional Feature:
- Macro: RV_UPSIZER_LAST_EN.
- Defined:
  - An accepted beat with last_in=1 forces completion at the current lane count cnt.
  - keep_out bit i = 1 for lanes 0..cnt; unused lanes are driven 0 in data_out.
  - last_out=1 with that word; cnt -> 0.
  - ready_out for a flush beat uses the same rule as a completion: (~valid_out | ready_in) when the beat would complete.
  - Hence ready_out = ~(valid_out & ~ready_in) | (cnt != RATIO-1 & ~last_in).
- Undefined:
  - last_in is ignored and last_out is tied 0.
  - keep_out is all ones whenever valid_out=1.

Test Plan (DATA_WIDTH=8, RATIO=4):
- Reset, then beats 0x11,0x22,0x33,0x44 back-to-back with ready_in=1 -> one cycle after the 4th accept: valid_out=1, data_out=0x44332211, keep_out=0xF.
- 12 continuous beats with ready_in=1 -> valid_out pulses three times with no bubbles on ready_out: 0x44332211, 0x88776655, 0xCCBBAA99.
- Hold ready_in=0 with a word pending; send 3 more beats and offer a 4th -> ready_out=0 on the 4th and the output holds 0x44332211. Raise ready_in -> same-edge drain and load, new word appears, valid_out stays 1.
- Assert reset after 2 accepted beats, then send 0xA1..0xA4 -> output 0xA4A3A2A1, with no stale lanes.
- RV_UPSIZER_LAST_EN: beats 0x01,0x02 with last_in on 0x02 -> data_out=0x00000201, keep_out=0x3, last_out=1; the next word starts at lane 0.
- Random valid_in/ready_in over 10k beats vs. a reference model -> no loss, duplication or reorder; output stable while stalled.
